// File: rtl/mem_fill_d1.sv
// Go/done fill engine: writes a (possibly ramped) value to a run of std_mem_d1 words, one write at a time.
// Optional read-back check of each written word is enabled by defining MEM_FILL_READBACK_EN.
module mem_fill_d1 #(
  parameter int                 WIDTH    = 32,
  parameter int                 SIZE     = 16,
  parameter int                 IDX_SIZE = 4,
  parameter logic [WIDTH-1:0]   STEP     = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  output logic                done,
  input  logic [IDX_SIZE-1:0] base,
  input  logic [IDX_SIZE:0]   count,
  input  logic [WIDTH-1:0]    fill_value,
  output logic                mismatch,
  output logic [IDX_SIZE-1:0] mem0_addr0,
  output logic [WIDTH-1:0]    mem0_write_data,
  output logic                mem0_write_en,
  output logic                mem0_clk,
  input  logic [WIDTH-1:0]    mem0_read_data,
  input  logic                mem0_done,
  output logic [1:0]          dbg_state
);

  // Handshake: each write is a one-cycle mem0_write_en; the next write is issued only after
  // mem0_done is observed in WAIT. go is sampled only in IDLE; done is a one-cycle pulse.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WAIT, S_DONE} state_t;

  localparam logic [IDX_SIZE-1:0] LAST_ADDR = IDX_SIZE'(SIZE - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_SIZE-1:0] r_addr;
  logic [WIDTH-1:0]    r_data;
  logic [IDX_SIZE:0]   r_remaining;
  logic                w_busy;
  logic                w_word_done;

  assign w_word_done = (r_state == S_WAIT) && mem0_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_data      <= '0;
      r_remaining <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && go) begin
        r_addr      <= base;
        r_data      <= fill_value;
        r_remaining <= count;
      end else if (w_word_done) begin
        r_remaining <= r_remaining - 1'b1;
        r_addr      <= (r_addr == LAST_ADDR) ? '0 : r_addr + 1'b1;
        r_data      <= r_data + STEP;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (go) w_state_nxt = (count == '0) ? S_DONE : S_WRITE;
      S_WRITE: w_state_nxt = S_WAIT;
      // remaining is compared before its decrement, so 1 means this was the last word
      S_WAIT:  if (mem0_done) w_state_nxt = (r_remaining == (IDX_SIZE+1)'(1)) ? S_DONE : S_WRITE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy          = (r_state == S_WRITE) || (r_state == S_WAIT);
  assign mem0_addr0      = w_busy ? r_addr : '0;
  assign mem0_write_data = w_busy ? r_data : '0;
  assign mem0_write_en   = (r_state == S_WRITE);
  assign done            = (r_state == S_DONE);
  assign mem0_clk        = clk;
  assign dbg_state       = r_state;

`ifdef MEM_FILL_READBACK_EN
  logic r_mismatch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mismatch <= 1'b0;
    end else if (r_state == S_IDLE && go) begin
      r_mismatch <= 1'b0;
    end else if (w_word_done && (mem0_read_data != r_data)) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_rd;
  assign w_unused_rd = ^mem0_read_data;
  assign mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_fill_d1.sv
// Bench for mem_fill_d1: a memory model with variable write latency, a write/done scoreboard,
// and a second small instance exercising a constant fill on a two-word memory.
module tb_mem_fill_d1;
  localparam int W  = 8;
  localparam int SZ = 12;
  localparam int IW = 4;
  localparam logic [W-1:0] ST = 8'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main instance
  logic          go = 1'b0;
  logic [IW-1:0] base = '0;
  logic [IW:0]   count = '0;
  logic [W-1:0]  fill = '0;
  logic          done, mismatch, wen, mclk, mdone;
  logic [IW-1:0] addr;
  logic [W-1:0]  wdata, rdata;
  logic [1:0]    dbg_state;

  mem_fill_d1 #(.WIDTH(W), .SIZE(SZ), .IDX_SIZE(IW), .STEP(ST)) dut (
    .clk(clk), .reset(reset), .go(go), .done(done), .base(base), .count(count),
    .fill_value(fill), .mismatch(mismatch), .mem0_addr0(addr), .mem0_write_data(wdata),
    .mem0_write_en(wen), .mem0_clk(mclk), .mem0_read_data(rdata), .mem0_done(mdone),
    .dbg_state(dbg_state)
  );

  // memory model: done arrives lat cycles after write_en; optional read corruption of word 5
  logic [W-1:0] mem [SZ];
  logic [W-1:0] ref_mem [SZ];
  int   lat = 1;
  int   dcnt = 0;
  logic stray = 1'b0;
  logic force_bad = 1'b0;

  always @(posedge clk) begin
    if (wen && int'(addr) < SZ) mem[addr] <= wdata;
    if (wen) dcnt <= lat;
    else if (dcnt > 0) dcnt <= dcnt - 1;
  end
  assign mdone = (dcnt == 1) | stray;

  always_comb begin
    rdata = (int'(addr) < SZ) ? mem[addr] : '0;
    if (force_bad && addr == 4'd5) rdata[0] = 1'b0;
  end

  // small instance: constant fill on a two-word memory
  logic       s_go = 1'b0;
  logic [0:0] s_base = '0;
  logic [1:0] s_count = '0;
  logic [3:0] s_fill = '0;
  logic       s_done, s_mis, s_wen, s_mclk;
  logic       s_mdone = 1'b0;
  logic [0:0] s_addr;
  logic [3:0] s_wdata, s_rdata;
  logic [1:0] s_dbg;
  logic [3:0] s_mem [2];

  mem_fill_d1 #(.WIDTH(4), .SIZE(2), .IDX_SIZE(1), .STEP(4'd0)) dut_s (
    .clk(clk), .reset(reset), .go(s_go), .done(s_done), .base(s_base), .count(s_count),
    .fill_value(s_fill), .mismatch(s_mis), .mem0_addr0(s_addr), .mem0_write_data(s_wdata),
    .mem0_write_en(s_wen), .mem0_clk(s_mclk), .mem0_read_data(s_rdata), .mem0_done(s_mdone),
    .dbg_state(s_dbg)
  );

  always @(posedge clk) begin
    if (s_wen) s_mem[s_addr] <= s_wdata;
    s_mdone <= s_wen;
  end
  assign s_rdata = s_mem[s_addr];

  // scoreboard
  logic [IW+W-1:0] exp_q[$];
  int              done_q[$];
  int              n_chk = 0;
  int              n_pass = 0;
  logic [IW+W-1:0] mon_e;
  int              mon_d;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (wen) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_write", longint'({addr, wdata}), -1);
        else begin
          mon_e = exp_q.pop_front();
          chk({addr, wdata} == mon_e, "write_addr_data", longint'({addr, wdata}), longint'(mon_e));
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk(1'b0, "unexpected_done", cyc, -1);
        else begin
          mon_d = done_q.pop_front();
          chk(cyc == mon_d, "done_cycle", cyc, mon_d);
        end
      end
    end
  end

  task automatic mem_check(input string name);
    int bad_i;
    bad_i = -1;
    for (int i = 0; i < SZ; i++)
      if (mem[i] !== ref_mem[i] && bad_i < 0) bad_i = i;
    if (bad_i < 0) chk(1'b1, name, 0, 0);
    else chk(1'b0, name, longint'(mem[bad_i]), longint'(ref_mem[bad_i]));
  endtask

  task automatic idle_strays();
    repeat ($urandom_range(2, 4)) begin
      @(posedge clk); #1 stray = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1 stray = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run(input int b, input int c, input logic [W-1:0] f, input int l,
                     input bit drop, input bit bad);
    logic [W-1:0] d;
    int a, t;
    bit mis;
    lat = l; force_bad = bad; d = f; a = b; mis = 1'b0;
    for (int k = 0; k < c; k++) begin
      exp_q.push_back({a[IW-1:0], d});
      ref_mem[a] = d;
      if (bad && a == 5 && d[0]) mis = 1'b1;
      a = (a + 1) % SZ;
      d = d + ST;
    end
`ifndef MEM_FILL_READBACK_EN
    mis = 1'b0;
`endif
    @(posedge clk); #1;
    base = b[IW-1:0]; count = c[IW:0]; fill = f; go = 1'b1;
    done_q.push_back(cyc + ((c == 0) ? 1 : c * (l + 1) + 1));
    if (drop) begin @(posedge clk); #1 go = 1'b0; end
    t = 0;
    while (!done && t < 400) begin @(negedge clk); t++; end
    chk(done === 1'b1, "done_seen", t, 400);
    @(posedge clk); #1 go = 1'b0;
    chk(mismatch === mis, "mismatch", mismatch, mis);
    mem_check("mem_contents");
    idle_strays();
  endtask

  task automatic reset_abort();
    logic [W-1:0] d;
    int a, n_we, n_dn, t;
    lat = 1; force_bad = 1'b0; a = 3; d = W'($urandom);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back({a[IW-1:0], d});
      ref_mem[a] = d;
      a = a + 1;
      d = d + ST;
    end
    @(posedge clk); #1;
    base = 4'd3; count = 5'd5; fill = d - ST - ST; go = 1'b1;
    n_we = 0; t = 0;
    while (n_we < 2 && t < 50) begin
      @(negedge clk); t++;
      if (wen) n_we++;
    end
    chk(n_we == 2, "abort_prewrites", n_we, 2);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; go = 1'b0;
    chk(addr == '0 && wdata == '0, "abort_outputs_zero", longint'({addr, wdata}), 0);
    n_we = 0; n_dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (wen) n_we++;
      if (done) n_dn++;
    end
    chk(n_we == 0, "abort_no_write", n_we, 0);
    chk(n_dn == 0, "abort_no_done", n_dn, 0);
    mem_check("abort_mem");
  endtask

  task automatic small_run(input int b, input int c, input logic [3:0] f);
    logic [4:0] sq[$];
    logic [4:0] e;
    logic [3:0] sref [2];
    int a, start, t;
    sref[0] = s_mem[0]; sref[1] = s_mem[1];
    a = b;
    for (int k = 0; k < c; k++) begin
      sq.push_back({a[0], f});
      sref[a] = f;
      a = (a + 1) % 2;
    end
    @(posedge clk); #1;
    s_base = b[0:0]; s_count = c[1:0]; s_fill = f; s_go = 1'b1;
    start = cyc;
    t = 0;
    while (!s_done && t < 50) begin
      @(negedge clk); t++;
      if (s_wen) begin
        if (sq.size() == 0) chk(1'b0, "small_unexpected_write", longint'({s_addr, s_wdata}), -1);
        else begin
          e = sq.pop_front();
          chk({s_addr, s_wdata} == e, "small_write", longint'({s_addr, s_wdata}), longint'(e));
        end
      end
    end
    chk(s_done === 1'b1 && cyc == start + 2 * c + 1, "small_done_cycle", cyc, start + 2 * c + 1);
    chk(sq.size() == 0, "small_writes_left", sq.size(), 0);
    @(posedge clk); #1 s_go = 1'b0;
    chk(s_mem[0] == sref[0] && s_mem[1] == sref[1], "small_mem",
        longint'({s_mem[1], s_mem[0]}), longint'({sref[1], sref[0]}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < SZ; i++) begin
      mem[i] = W'(8'hA0 + i);
      ref_mem[i] = W'(8'hA0 + i);
    end
    s_mem[0] = 4'd0; s_mem[1] = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(wen == 1'b0, "rst_write_en", wen, 0);
    chk(addr == '0, "rst_addr", addr, 0);
    chk(wdata == '0, "rst_wdata", wdata, 0);
    chk(mismatch == 1'b0, "rst_mismatch", mismatch, 0);
    chk(s_done == 1'b0 && s_wen == 1'b0, "rst_small", longint'({s_done, s_wen}), 0);
    @(posedge clk); #1 reset = 1'b0;

    small_run(0, 1, 4'd6);
    small_run(1, 3, 4'd9);

    run(2, 4, 8'd10, 1, 1'b0, 1'b0);
    run(10, 4, 8'd0, 1, 1'b0, 1'b0);
    run(5, 0, 8'd55, 1, 1'b0, 1'b0);
    run(0, 0, 8'd1, 1, 1'b1, 1'b0);
    run(7, 31, 8'd200, 1, 1'b1, 1'b0);
    run(0, 6, 8'd77, 3, 1'b0, 1'b0);
    run(4, 3, 8'd2, 1, 1'b0, 1'b1);
    run(4, 3, 8'd2, 1, 1'b0, 1'b0);
    reset_abort();
    for (int r = 0; r < 12; r++)
      run($urandom_range(0, SZ - 1), $urandom_range(0, 31), W'($urandom),
          $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    chk(exp_q.size() == 0, "writes_outstanding", exp_q.size(), 0);
    chk(done_q.size() == 0, "dones_outstanding", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
